lvc_ahb_slave_mem: RTL and testbench
====================================

LVC_AHB_SLAVE_MEM -- requirements
Module: lvc_ahb_slave_mem

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is hclk, and the reset is hresetn, synchronous and active-low.
REQ-002 Parameter ADDR_WIDTH, default 16: width of haddr.
REQ-003 Parameter DATA_WIDTH, default 32: width of hwdata and hrdata; legal values 32 and 64.
REQ-004 Parameter MEM_DEPTH, default 1024: number of DATA_WIDTH-bit words in the internal array.
REQ-005 Parameter WAIT_STATES, default 0: wait cycles inserted per OKAY transfer; legal range 0..15.
REQ-006 Ports (name  direction  width  meaning):
- hclk  in  1  clock
- hresetn  in  1  synchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  byte address
- htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  transfer size, bytes = 2^hsize
- hburst  in  3  burst type; accepted but not used
- hprot  in  4  protection; accepted but not used
- hwdata  in  DATA_WIDTH  write data
- hready  in  1  bus-level ready
- hreadyout  out  1  slave ready
- hresp  out  2  response: OKAY=00, ERROR=01
- hrdata  out  DATA_WIDTH  read data

Function
REQ-007 A transfer SHALL be accepted at a rising hclk edge when hsel=1, hready=1 and htrans[1]=1; on acceptance, haddr, hwrite and hsize SHALL be registered.
REQ-008 IDLE or BUSY with hsel=1 and hready=1 SHALL give a zero-wait OKAY response and SHALL NOT access memory.
REQ-009 An accepted transfer is in error when any of the following holds:
- hsize > log2(DATA_WIDTH/8);
- haddr is not aligned to 2^hsize;
- word index haddr/(DATA_WIDTH/8) >= MEM_DEPTH.
REQ-010 The FSM SHALL have exactly these states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-011 Outputs SHALL decode from state as follows:
- IDLE and DATA: hreadyout=1, hresp=OKAY;
- WAIT: hreadyout=0, hresp=OKAY;
- ERR1: hreadyout=0, hresp=ERROR;
- ERR2: hreadyout=1, hresp=ERROR.
REQ-012 From IDLE, DATA or ERR2, the next state SHALL be:
- on an accepted error transfer: ERR1;
- on an accepted legal transfer: WAIT if the effective wait count > 0, else DATA;
- with no acceptance: IDLE.
REQ-013 The WAIT state SHALL load a down-counter with the effective wait count and exit to DATA after exactly that many cycles.
REQ-014 ERR1 SHALL always go to ERR2, giving a two-cycle ERROR response.
REQ-015 A write SHALL commit in the DATA cycle, at its closing edge, using hwdata.
- Only the 2^hsize byte lanes selected by haddr[log2(DATA_WIDTH/8)-1:0] are written (little-endian lanes).
- All other bytes are unchanged.
REQ-016 A read SHALL drive hrdata with the full addressed word during its DATA cycle; hrdata SHALL be 0 in all other states.
REQ-017 Error transfers SHALL NOT modify memory.
REQ-018 Read-after-write: a read accepted during the DATA cycle of a write to the same word SHALL return the newly written bytes.
REQ-019 Back-to-back pipelined transfers with zero waits SHALL complete one per cycle.

Reset
REQ-020 While hresetn=0 at a rising edge, the block SHALL reset to: state=IDLE, wait counter=0, registered controls=0, hreadyout=1, hresp=OKAY, hrdata=0.
REQ-021 Reset SHALL NOT clear memory contents.
REQ-022 Reset asserted during WAIT, ERR1 or ERR2 SHALL abort the transfer; a pending write SHALL NOT commit.

Configuration
REQ-023 Wait-state insertion SHALL be controlled by the macro LVC_AHB_SLAVE_WAIT_EN:
- defined: the effective wait count = WAIT_STATES;
- undefined: the effective wait count = 0, WAIT is unreachable, and its counter is not synthesized.

Verification
REQ-024 Zero-wait, 32-bit: write 0xDEADBEEF to 0x0010, then read 0x0010 -> hrdata=0xDEADBEEF in the DATA cycle, hresp=OKAY, hreadyout=1 throughout.
REQ-025 Byte lanes: word 0x0020 holds 0x00000000; write 0xAA (hsize=0) to 0x0022 -> a read of 0x0020 returns 0x00AA0000.
REQ-026 Waits: with LVC_AHB_SLAVE_WAIT_EN defined and WAIT_STATES=3, a NONSEQ read -> hreadyout=0 for exactly 3 cycles, then 1 with the data.
REQ-027 Errors: with MEM_DEPTH=1024, a write to 0x1000 -> hresp=ERROR for 2 cycles, hreadyout 0 then 1, and memory is unchanged; a halfword access to 0x0001 -> the same ERROR sequence.
REQ-028 Pipeline and reset: NONSEQ write 0x0, SEQ write 0x4, SEQ write 0x8 back-to-back -> 3 consecutive OKAY/ready cycles; hresetn=0 during a WAIT cycle -> IDLE next cycle with hreadyout=1, and that write is absent from memory.

Source files
------------

// File: rtl/lvc_ahb_slave_mem.sv
// AHB-Lite slave with an internal word-organised memory.
// Accepts single and pipelined transfers, writes byte lanes little-endian,
// answers illegal transfers with a two-cycle ERROR response.
// Optional wait-state insertion is enabled by defining LVC_AHB_SLAVE_WAIT_EN;
// without it every legal transfer is zero-wait and the wait counter is absent.

module lvc_ahb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned ByteBits = $clog2(NumBytes);
    localparam int unsigned IdxBits  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned AddrExtW = ADDR_WIDTH + 1;

    // Depth widened by one bit so the range compare never truncates.
    localparam logic [ADDR_WIDTH:0] DepthCmp = AddrExtW'(MEM_DEPTH);

    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespError = 2'b01;

`ifdef LVC_AHB_SLAVE_WAIT_EN
    localparam logic [3:0] EffWait = 4'(WAIT_STATES);
`else
    localparam logic [3:0] EffWait = 4'd0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Address-phase controls captured on acceptance.
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_accept;
    logic                  w_size_err;
    logic                  w_align_err;
    logic                  w_range_err;
    logic                  w_xfer_err;
    logic [ADDR_WIDTH-1:0] w_align_mask;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic [IdxBits-1:0]    w_mem_idx;
    logic [ByteBits-1:0]   w_lane;
    logic [NumBytes-1:0]   w_byte_en;
    logic                  w_wr_commit;

`ifdef LVC_AHB_SLAVE_WAIT_EN
    logic [3:0] r_wait_cnt;
`endif

    // Only IDLE, DATA and ERR2 drive hreadyout high, so acceptance is
    // naturally restricted to those states.
    assign w_accept = hsel && hready && htrans[1] && hreadyout;

    // Legality of the transfer currently presented in the address phase.
    always_comb begin
        w_size_err   = (hsize > 3'(ByteBits));
        w_align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
        w_align_err  = |(haddr & w_align_mask);
        w_word_idx   = haddr >> ByteBits;
        w_range_err  = ({1'b0, w_word_idx} >= DepthCmp);
        w_xfer_err   = w_size_err || w_align_err || w_range_err;
    end

    assign w_mem_idx   = IdxBits'(r_addr >> ByteBits);
    assign w_lane      = r_addr[ByteBits-1:0];
    // A reset edge that closes a DATA cycle wins over the write.
    assign w_wr_commit = hresetn && (r_state == StData) && r_write;

    // Byte lanes covered by the registered transfer, starting at the lane offset.
    always_comb begin
        w_byte_en = '0;
        for (int i = 0; i < int'(NumBytes); i++) begin
            if ((i >= int'(w_lane)) && (i < (int'(w_lane) + (1 << r_size)))) begin
                w_byte_en[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Address-phase capture on every accepted transfer, legal or not.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
        end else if (w_accept) begin
            r_addr  <= haddr;
            r_write <= hwrite;
            r_size  <= hsize;
        end
    end

`ifdef LVC_AHB_SLAVE_WAIT_EN
    // Wait down-counter: loaded on legal acceptance, counts through WAIT.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_wait_cnt <= '0;
        end else if (w_accept && !w_xfer_err) begin
            r_wait_cnt <= EffWait;
        end else if ((r_state == StWait) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StData, StErr2: begin
                if (w_accept) begin
                    if (w_xfer_err) begin
                        w_state_next = StErr1;
                    end else if (EffWait != 4'd0) begin
                        w_state_next = StWait;
                    end else begin
                        w_state_next = StData;
                    end
                end else begin
                    w_state_next = StIdle;
                end
            end
            StWait: begin
`ifdef LVC_AHB_SLAVE_WAIT_EN
                // The counter still holds 1 during the last wait cycle.
                if (r_wait_cnt <= 4'd1) begin
                    w_state_next = StData;
                end else begin
                    w_state_next = StWait;
                end
`else
                w_state_next = StData;
`endif
            end
            StErr1: begin
                w_state_next = StErr2;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decode; read data is only visible during a read DATA cycle.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = RespOkay;
        hrdata    = '0;
        unique case (r_state)
            StWait: begin
                hreadyout = 1'b0;
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = RespError;
            end
            StErr2: begin
                hresp = RespError;
            end
            StData: begin
                if (!r_write) begin
                    hrdata = r_mem[w_mem_idx];
                end
            end
            default: begin
            end
        endcase
    end

    // Memory write at the closing edge of a write DATA cycle; no reset so
    // contents survive hresetn.
    always_ff @(posedge hclk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < int'(NumBytes); i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Signals accepted on the bus but not needed by this slave.
    logic w_unused;
`ifdef LVC_AHB_SLAVE_WAIT_EN
    assign w_unused = ^{hburst, hprot, htrans[0], r_addr};
`else
    assign w_unused = ^{hburst, hprot, htrans[0], r_addr, 4'(WAIT_STATES)};
`endif

endmodule

// File: tb/tb_lvc_ahb_slave_mem.sv
// Bench for lvc_ahb_slave_mem: directed AHB vectors, a byte-addressed
// reference model predicting every response cycle, and literal expectations
// attached to each vector.

module tb_lvc_ahb_slave_mem;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int NB    = DW / 8;
`ifdef LVC_AHB_SLAVE_WAIT_EN
    localparam int EffW = 3;
`else
    localparam int EffW = 0;
`endif
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] ER = 2'b01;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hreadyout;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;

    // Single-slave bus: the slave's ready is the bus ready.
    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    lvc_ahb_slave_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(3)
    ) u_dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hready   (hready),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic          rdy;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        bit            wdat;
        int            addr;
        int            size;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic [7:0] m_mem [0:DEPTH*NB-1];

    function automatic exp_t mk_exp(input logic rdy, input logic [1:0] resp,
                                    input logic [DW-1:0] rdata, input bit wdat,
                                    input int addr, input int size);
        exp_t e;
        e.rdy = rdy; e.resp = resp; e.rdata = rdata;
        e.wdat = wdat; e.addr = addr; e.size = size;
        return e;
    endfunction

    function automatic logic [DW-1:0] model_word(input int byte_addr);
        logic [DW-1:0] w;
        int base;
        base = (byte_addr / NB) * NB;
        for (int b = 0; b < NB; b++) w[8*b +: 8] = m_mem[base + b];
        return w;
    endfunction

    // Each posedge: retire the write whose data cycle just ended, then queue
    // the response cycles of a newly accepted transfer.
    initial begin
        forever begin
            @(posedge hclk);
            if (!hresetn) begin
                exp_q.delete();
            end else begin
                if (cur.wdat) begin
                    for (int b = 0; b < (1 << cur.size); b++) begin
                        m_mem[cur.addr + b] = hwdata[8*((cur.addr % NB) + b) +: 8];
                    end
                end
                if (hsel && htrans[1] && cur.rdy) begin
                    int a;
                    int nbytes;
                    bit err;
                    a      = int'(haddr);
                    nbytes = 1 << int'(hsize);
                    err    = (nbytes > NB) || ((a % nbytes) != 0) || ((a / NB) >= DEPTH);
                    if (err) begin
                        exp_q.push_back(mk_exp(1'b0, ER, '0, 1'b0, 0, 0));
                        exp_q.push_back(mk_exp(1'b1, ER, '0, 1'b0, 0, 0));
                    end else begin
                        for (int k = 0; k < EffW; k++) begin
                            exp_q.push_back(mk_exp(1'b0, OK, '0, 1'b0, 0, 0));
                        end
                        exp_q.push_back(mk_exp(1'b1, OK, hwrite ? '0 : model_word(a),
                                               hwrite, a, int'(hsize)));
                    end
                end
            end
        end
    end

    // Every cycle: compare DUT outputs with the model's expectation.
    initial begin
        forever begin
            @(negedge hclk);
            if (cmp_en) begin
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                else cur = mk_exp(1'b1, OK, '0, 1'b0, 0, 0);
                check("cycle_rdy_resp_rdata", {hreadyout, hresp, hrdata},
                      {cur.rdy, cur.resp, cur.rdata});
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        string         name;
        logic [1:0]    trans;
        logic [AW-1:0] addr;
        logic          wr;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
        logic [DW-1:0] lrd;
        logic [1:0]    lresp;
        int            lwait;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string name, input logic [1:0] t, input logic [AW-1:0] a,
                       input logic w, input logic [2:0] s, input logic [DW-1:0] wd,
                       input logic [DW-1:0] lrd, input logic [1:0] lresp, input int lwait);
        vec_t v;
        v.name = name; v.trans = t; v.addr = a; v.wr = w; v.size = s;
        v.wdata = wd; v.lrd = lrd; v.lresp = lresp; v.lwait = lwait;
        vq.push_back(v);
    endtask

    // Drives each address phase with the previous beat's write data and checks
    // the previous beat's stall count, final response and read data.
    task automatic run_vecs();
        vec_t prev;
        bit   have_prev;
        bit   done;
        int   n_wait;
        have_prev = 1'b0;
        for (int i = 0; i <= vq.size(); i++) begin
            if (i < vq.size()) begin
                hsel = 1'b1; htrans = vq[i].trans; haddr = vq[i].addr;
                hwrite = vq[i].wr; hsize = vq[i].size;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            hwdata = have_prev ? prev.wdata : '0;
            n_wait = 0;
            done   = 1'b0;
            for (int c = 0; c < 64 && !done; c++) begin
                @(negedge hclk);
                if (hreadyout) begin
                    done = 1'b1;
                    if (have_prev) begin
                        check({prev.name, "_wait"}, 64'(n_wait), 64'(prev.lwait));
                        check({prev.name, "_resp"}, 64'(hresp), 64'(prev.lresp));
                        check({prev.name, "_rdata"}, 64'(hrdata), 64'(prev.lrd));
                    end
                end else begin
                    n_wait++;
                end
                @(posedge hclk);
                #1;
            end
            if (!done) check("step_timeout", 64'd0, 64'd1);
            if (i < vq.size()) begin
                prev = vq[i];
                have_prev = 1'b1;
            end
        end
        vq.delete();
        hwdata = '0;
    endtask

    // Accept a write, then assert reset during its first stall cycle.
    task automatic abort_with_reset(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                    input logic [1:0] stall_resp);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = 1'b1; hsize = 3'd2;
        @(negedge hclk);
        check("abort_pre_ready", 64'(hreadyout), 64'd1);
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        @(negedge hclk);
        check("abort_stall_ready", 64'(hreadyout), 64'd0);
        check("abort_stall_resp", 64'(hresp), 64'(stall_resp));
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        hwdata  = '0;
        @(negedge hclk);
        check("abort_post_ready", 64'(hreadyout), 64'd1);
        check("abort_post_resp", 64'(hresp), 64'(OK));
        check("abort_post_rdata", 64'(hrdata), 64'd0);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        cur     = mk_exp(1'b1, OK, '0, 1'b0, 0, 0);
        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize   = 3'd0; hburst = 3'b001; hprot = 4'b0011; hwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        cmp_en = 1'b1;
        @(negedge hclk);
        check("reset_ready", 64'(hreadyout), 64'd1);
        check("reset_resp", 64'(hresp), 64'(OK));
        check("reset_rdata", 64'(hrdata), 64'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;

        add("w_0000",    2'b10, 16'h0000, 1, 3'd2, 32'h1111_1111, '0,            OK, EffW);
        add("w_0040",    2'b10, 16'h0040, 1, 3'd2, 32'h5555_5555, '0,            OK, EffW);
        add("w_0010",    2'b10, 16'h0010, 1, 3'd2, 32'hDEAD_BEEF, '0,            OK, EffW);
        add("r_0010",    2'b10, 16'h0010, 0, 3'd2, '0,            32'hDEAD_BEEF, OK, EffW);
        add("w_0020",    2'b10, 16'h0020, 1, 3'd2, 32'h0000_0000, '0,            OK, EffW);
        add("wb_0022",   2'b10, 16'h0022, 1, 3'd0, 32'h00AA_0000, '0,            OK, EffW);
        add("r_0020",    2'b10, 16'h0020, 0, 3'd2, '0,            32'h00AA_0000, OK, EffW);
        add("idle_sel",  2'b00, 16'h0030, 0, 3'd2, '0,            '0,            OK, 0);
        add("busy_sel",  2'b01, 16'h0030, 1, 3'd2, '0,            '0,            OK, 0);
        add("w_oob",     2'b10, 16'h1000, 1, 3'd2, 32'h1234_5678, '0,            ER, 1);
        add("wh_misal",  2'b10, 16'h0001, 1, 3'd1, 32'hFFFF_FFFF, '0,            ER, 1);
        add("r_bigsize", 2'b10, 16'h0008, 0, 3'd3, '0,            '0,            ER, 1);
        add("r_0000_a",  2'b10, 16'h0000, 0, 3'd2, '0,            32'h1111_1111, OK, EffW);
        add("pw_0000",   2'b10, 16'h0000, 1, 3'd2, 32'hA0A0_A0A0, '0,            OK, EffW);
        add("pw_0004",   2'b11, 16'h0004, 1, 3'd2, 32'hB1B1_B1B1, '0,            OK, EffW);
        add("pw_0008",   2'b11, 16'h0008, 1, 3'd2, 32'hC3C2_C1C0, '0,            OK, EffW);
        add("wh_0006",   2'b10, 16'h0006, 1, 3'd1, 32'hCAFE_0000, '0,            OK, EffW);
        add("r_raw_0004",2'b10, 16'h0004, 0, 3'd2, '0,            32'hCAFE_B1B1, OK, EffW);
        add("rb_0009",   2'b10, 16'h0009, 0, 3'd0, '0,            32'hC3C2_C1C0, OK, EffW);
        add("r_0000_b",  2'b10, 16'h0000, 0, 3'd2, '0,            32'hA0A0_A0A0, OK, EffW);
        add("wh_0012",   2'b10, 16'h0012, 1, 3'd1, 32'h1234_0000, '0,            OK, EffW);
        add("r_0010_b",  2'b10, 16'h0010, 0, 3'd2, '0,            32'h1234_BEEF, OK, EffW);
        add("w_0ffc",    2'b10, 16'h0FFC, 1, 3'd2, 32'h0BAD_F00D, '0,            OK, EffW);
        add("r_0ffc",    2'b10, 16'h0FFC, 0, 3'd2, '0,            32'h0BAD_F00D, OK, EffW);
        run_vecs();

`ifdef LVC_AHB_SLAVE_WAIT_EN
        abort_with_reset(16'h0040, 32'hFFFF_FFFF, OK);
`else
        abort_with_reset(16'h1000, 32'hFFFF_FFFF, ER);
`endif

        add("r_0040",    2'b10, 16'h0040, 0, 3'd2, '0,            32'h5555_5555, OK, EffW);
        add("r_0020_b",  2'b10, 16'h0020, 0, 3'd2, '0,            32'h00AA_0000, OK, EffW);
        run_vecs();

        repeat (3) @(posedge hclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
